// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control path: opcodes, ALU operation classes
// and the packed control bundle carried across the ID/EX boundary.
package cpu_pkg;

    localparam int OPW  = 6;
    localparam int AOPW = 3;

    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_ADDI  = 6'b000001;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPW-1:0] OP_LW    = 6'b000110;
    localparam logic [OPW-1:0] OP_SW    = 6'b000111;

    // Codes 100-111 are reserved and never produced by the decoder.
    localparam logic [AOPW-1:0] ALUOP_ADD     = 3'b000;
    localparam logic [AOPW-1:0] ALUOP_SUB_BEQ = 3'b001;
    localparam logic [AOPW-1:0] ALUOP_RTYPE   = 3'b010;
    localparam logic [AOPW-1:0] ALUOP_SUB_BNE = 3'b011;

    typedef struct packed {
        logic            regDst;
        logic            aluSrc;
        logic            memToReg;
        logic            regWrite;
        logic            memRead;
        logic            memWrite;
        logic            branch;
        logic [AOPW-1:0] aluOp;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/control_decoder.sv
// Combinational main decoder: opcode to control bundle. Unknown opcodes decode
// to a bubble with illegal raised, so they can never write state.
module control_decoder
    import cpu_pkg::*;
(
    input  logic [OPW-1:0] opCode,
    output ctrl_t          ctrl,
    output logic           illegal
);

    always_comb begin
        ctrl    = CTRL_BUBBLE;
        illegal = 1'b0;
        case (opCode)
            OP_RTYPE: begin
                ctrl.regDst   = 1'b1;
                ctrl.regWrite = 1'b1;
                ctrl.aluOp    = ALUOP_RTYPE;
            end
            OP_ADDI: begin
                ctrl.aluSrc   = 1'b1;
                ctrl.regWrite = 1'b1;
                ctrl.aluOp    = ALUOP_ADD;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.aluOp  = ALUOP_SUB_BEQ;
            end
            OP_BNE: begin
                ctrl.branch = 1'b1;
                ctrl.aluOp  = ALUOP_SUB_BNE;
            end
            OP_LW: begin
                ctrl.aluSrc   = 1'b1;
                ctrl.memToReg = 1'b1;
                ctrl.regWrite = 1'b1;
                ctrl.memRead  = 1'b1;
                ctrl.aluOp    = ALUOP_ADD;
            end
            // Store drives regDst/memToReg low even though they are unused.
            OP_SW: begin
                ctrl.aluSrc   = 1'b1;
                ctrl.memWrite = 1'b1;
                ctrl.aluOp    = ALUOP_ADD;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pipeline_control_unit.sv
// ID-stage main decoder with its ID/EX control register; the hazard unit
// can hold the register (stall) or load a bubble (flush, which wins).
module pipeline_control_unit
    import cpu_pkg::*;
#(
    parameter int OPW_P  = OPW,
    parameter int AOPW_P = AOPW
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic [OPW_P-1:0]  opCode,
    input  logic              stall,
    input  logic              flush,
    output logic              regDst,
    output logic              aluSrc,
    output logic              memToReg,
    output logic              regWrite,
    output logic              memRead,
    output logic              memWrite,
    output logic              branch,
    output logic [AOPW_P-1:0] aluOp,
    output logic              illegal
);

    ctrl_t decCtrl;
    logic  decIllegal;
    ctrl_t ctrlReg;
    logic  illegalReg;

    control_decoder uDecoder (
        .opCode  (opCode),
        .ctrl    (decCtrl),
        .illegal (decIllegal)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ctrlReg    <= CTRL_BUBBLE;
            illegalReg <= 1'b0;
        end else if (flush) begin
            ctrlReg    <= CTRL_BUBBLE;
            illegalReg <= 1'b0;
        end else if (!stall) begin
            ctrlReg    <= decCtrl;
            illegalReg <= decIllegal;
        end
    end

    assign regDst   = ctrlReg.regDst;
    assign aluSrc   = ctrlReg.aluSrc;
    assign memToReg = ctrlReg.memToReg;
    assign regWrite = ctrlReg.regWrite;
    assign memRead  = ctrlReg.memRead;
    assign memWrite = ctrlReg.memWrite;
    assign branch   = ctrlReg.branch;
    assign aluOp    = ctrlReg.aluOp;
    assign illegal  = illegalReg;

    // Structural invariants of the registered bundle.
    always @(posedge clk) begin
        if (rstN) begin
            assert (!(ctrlReg.memRead && ctrlReg.memWrite));
            assert (!ctrlReg.branch || (!ctrlReg.regWrite && !ctrlReg.memWrite));
            assert (!illegalReg || (ctrlReg == CTRL_BUBBLE));
            assert (!ctrlReg.aluOp[2]);
        end
    end

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench for pipeline_control_unit; expected bundles are hand-written
// as {regDst,aluSrc,memToReg,regWrite,memRead,memWrite,branch,aluOp,illegal}.
module tb_pipeline_control_unit;

    logic       clk = 1'b0;
    logic       rstN;
    logic [5:0] opCode;
    logic       stall;
    logic       flush;
    logic       regDst, aluSrc, memToReg, regWrite, memRead, memWrite, branch;
    logic [2:0] aluOp;
    logic       illegal;

    int errors = 0;
    int checks = 0;

    localparam logic [10:0] EXP_ZERO = 11'b0000000_000_0;
    localparam logic [10:0] EXP_R    = 11'b1001000_010_0;
    localparam logic [10:0] EXP_ADDI = 11'b0101000_000_0;
    localparam logic [10:0] EXP_BEQ  = 11'b0000001_001_0;
    localparam logic [10:0] EXP_BNE  = 11'b0000001_011_0;
    localparam logic [10:0] EXP_LW   = 11'b0111100_000_0;
    localparam logic [10:0] EXP_SW   = 11'b0100010_000_0;
    localparam logic [10:0] EXP_ILL  = 11'b0000000_000_1;

    pipeline_control_unit dut (
        .clk      (clk),
        .rstN     (rstN),
        .opCode   (opCode),
        .stall    (stall),
        .flush    (flush),
        .regDst   (regDst),
        .aluSrc   (aluSrc),
        .memToReg (memToReg),
        .regWrite (regWrite),
        .memRead  (memRead),
        .memWrite (memWrite),
        .branch   (branch),
        .aluOp    (aluOp),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] observed();
        return {regDst, aluSrc, memToReg, regWrite, memRead, memWrite, branch, aluOp, illegal};
    endfunction

    task automatic check(input string tag, input logic [10:0] exp);
        logic [10:0] obs;
        obs = observed();
        checks++;
        assert (obs === exp) begin
            $display("check %-14s op=%b stall=%b flush=%b outs=%b", tag, opCode, stall, flush, obs);
        end else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Apply inputs, take one rising edge, then settle 1 time unit past it.
    task automatic step(input logic [5:0] op, input logic st, input logic fl);
        opCode = op;
        stall  = st;
        flush  = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstN   = 1'b0;
        opCode = 6'b000000;
        stall  = 1'b0;
        flush  = 1'b0;
        #1;
        check("reset_t0", EXP_ZERO);
        step(6'b000000, 1'b0, 1'b0);
        check("reset_held", EXP_ZERO);
        rstN = 1'b1;
        step(6'b000000, 1'b0, 1'b0);
        check("after_reset_R", EXP_R);

        step(6'b000100, 1'b0, 1'b0);
        check("sweep_BEQ", EXP_BEQ);
        step(6'b000101, 1'b0, 1'b0);
        check("sweep_BNE", EXP_BNE);
        step(6'b000111, 1'b0, 1'b0);
        check("sweep_SW", EXP_SW);
        step(6'b000110, 1'b0, 1'b0);
        check("sweep_LW", EXP_LW);
        step(6'b000001, 1'b0, 1'b0);
        check("sweep_ADDI", EXP_ADDI);
        step(6'b000000, 1'b0, 1'b0);
        check("sweep_R", EXP_R);

        step(6'b100011, 1'b0, 1'b0);
        check("unknown_100011", EXP_ILL);
        step(6'b000001, 1'b0, 1'b0);
        check("ill_to_ADDI", EXP_ADDI);
        step(6'b111111, 1'b0, 1'b0);
        check("unknown_111111", EXP_ILL);
        step(6'b000010, 1'b0, 1'b0);
        check("unknown_000010", EXP_ILL);

        step(6'b000110, 1'b0, 1'b0);
        check("stall_pre_LW", EXP_LW);
        for (int i = 0; i < 3; i++) begin
            step(6'b000111, 1'b1, 1'b0);
            check("stall_hold_LW", EXP_LW);
        end
        #2;
        check("between_edges", EXP_LW);
        step(6'b000111, 1'b0, 1'b0);
        check("stall_rel_SW", EXP_SW);

        step(6'b000000, 1'b1, 1'b1);
        check("flush_over_stall", EXP_ZERO);
        step(6'b000000, 1'b0, 1'b0);
        check("flush_rel_R", EXP_R);
        step(6'b000110, 1'b0, 1'b1);
        check("flush_only", EXP_ZERO);

        step(6'b000110, 1'b0, 1'b0);
        check("pre_async_LW", EXP_LW);
        #2;
        rstN = 1'b0;
        #1;
        check("async_reset", EXP_ZERO);
        rstN = 1'b1;
        step(6'b000110, 1'b1, 1'b0);
        check("stall_after_rst", EXP_ZERO);
        step(6'b000110, 1'b0, 1'b0);
        check("lw_again", EXP_LW);
        stall = 1'b1;
        #2;
        rstN = 1'b0;
        #1;
        check("reset_mid_stall", EXP_ZERO);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
